// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared vectors, FSM state encodings and next-PC select codes for pc_unit
package pc_unit_pkg;

    localparam logic [31:0] DEF_RESET_VEC = 32'hBFC00000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'hBFC00180;

    typedef enum logic [1:0] {RUN, PEND_BR, PEND_EXC, PEND_NULL} state_t;

    typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_EXC, SEL_PEND} sel_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bus between the pipeline (master) and pc_unit (slave)
interface pc_unit_if;
    logic        Stall;
    logic        BrValid;
    logic        BrTaken;
    logic [31:0] BrTarget;
    logic        JmpValid;
    logic [31:0] JmpTarget;
    logic        ExcReq;
    logic        BrLikely;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic        SquashIF;
    logic        SquashID;
    logic        Pending;

    modport master (
        output Stall, BrValid, BrTaken, BrTarget, JmpValid, JmpTarget, ExcReq, BrLikely,
        input  PC, PCplus4, SquashIF, SquashID, Pending
    );

    modport slave (
        input  Stall, BrValid, BrTaken, BrTarget, JmpValid, JmpTarget, ExcReq, BrLikely,
        output PC, PCplus4, SquashIF, SquashID, Pending
    );
endinterface

// File: rtl/pc_unit_nextsel.sv
// pc_nextsel: combinational next-PC mux and squash decode; BRANCH_LIKELY_EN enables delay-slot nullify
module pc_nextsel
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
    input  state_t      state,
    input  logic        stall,
    input  logic        exc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_likely,
    input  logic        jmp_valid,
    input  logic [31:0] pc,
    input  logic [31:0] br_target,
    input  logic [31:0] jmp_target,
    input  logic [31:0] pend_tgt,
    output logic        br_hit,
    output logic        null_hit,
    output logic [31:0] next_pc,
    output logic        squash_if,
    output logic        squash_id
);
    sel_t sel;

    // pick the redirect source by priority: exception, held redirect, branch, jump, sequential
    always_comb begin
        br_hit = br_valid & br_taken;
`ifdef BRANCH_LIKELY_EN
        null_hit = br_valid & ~br_taken & br_likely;
`else
        null_hit = br_likely & 1'b0;
`endif
        sel = (exc || state == PEND_EXC) ? SEL_EXC :
              state == PEND_BR   ? SEL_PEND :
              state == PEND_NULL ? SEL_SEQ :
              br_hit             ? SEL_BR :
              jmp_valid          ? SEL_JMP : SEL_SEQ;
        next_pc = sel == SEL_EXC  ? EXC_VEC :
                  sel == SEL_PEND ? pend_tgt :
                  sel == SEL_BR   ? word_align(br_target) :
                  sel == SEL_JMP  ? word_align(jmp_target) : pc + 32'd4;
        squash_if = !stall && (sel == SEL_EXC || sel == SEL_PEND || sel == SEL_BR);
        squash_id = !stall && (sel == SEL_EXC || state == PEND_NULL ||
                               (state == RUN && sel == SEL_SEQ && null_hit));
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC, redirect FSM holding branch/exception redirects across stalls (BRANCH_LIKELY_EN adds PEND_NULL)
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);
    logic [31:0] pc, pend_tgt, next_pc;
    logic        pending, br_hit, null_hit;
    state_t      state, stall_state;

    pc_nextsel #(.EXC_VEC(EXC_VEC)) u_nextsel (
        .state      (state),
        .stall      (bus.Stall),
        .exc        (bus.ExcReq),
        .br_valid   (bus.BrValid),
        .br_taken   (bus.BrTaken),
        .br_likely  (bus.BrLikely),
        .jmp_valid  (bus.JmpValid),
        .pc         (pc),
        .br_target  (bus.BrTarget),
        .jmp_target (bus.JmpTarget),
        .pend_tgt   (pend_tgt),
        .br_hit     (br_hit),
        .null_hit   (null_hit),
        .next_pc    (next_pc),
        .squash_if  (bus.SquashIF),
        .squash_id  (bus.SquashID)
    );

    // state to park in while stalled; an exception overrides any held redirect, jumps are re-presented by ID
    always_comb begin
        stall_state = bus.ExcReq ? PEND_EXC :
                      state != RUN ? state :
                      br_hit ? PEND_BR :
                      null_hit ? PEND_NULL : RUN;
    end

    // PC register and redirect FSM; any unstalled cycle consumes the pending redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_VEC;
            pend_tgt <= '0;
            state    <= RUN;
            pending  <= 1'b0;
        end else if (!bus.Stall) begin
            pc      <= next_pc;
            state   <= RUN;
            pending <= 1'b0;
        end else begin
            if (state == RUN && br_hit && !bus.ExcReq) pend_tgt <= word_align(bus.BrTarget);
            state   <= stall_state;
            pending <= stall_state != RUN;
        end
    end

    assign bus.PC      = pc;
    assign bus.PCplus4 = pc + 32'd4;
    assign bus.Pending = pending;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Fetch-side consumer of the EX-stage quick-compare branch result (qc.Result): owns the architectural PC and selects the next fetch address.
- Handles sequential fetch, ID-stage jumps, EX-stage conditional branches with one MIPS delay slot, and exception redirects.
- Issues squash for the wrong-path instruction currently in IF.
- Holds redirects pending across pipeline stalls via a small FSM.

Parameters:
RESET_VEC, 32'hBFC00000, PC value loaded on reset
EXC_VEC, 32'hBFC00180, PC value loaded on exception redirect

Ports:
clk  input  1  single pipeline clock, rising edge
reset  input  1  asynchronous active-high reset
Stall  input  1  freeze IF/ID this cycle (hazard unit)
BrValid  input  1  conditional branch in EX this cycle
BrTaken  input  1  qc.Result for that branch
BrTarget  input  32  branch target computed in EX
JmpValid  input  1  J/JAL/JR/JALR decoded in ID this cycle
JmpTarget  input  32  jump target from ID
ExcReq  input  1  exception request (from EX/MEM)
BrLikely  input  1  EX branch is a branch-likely (used only with BRANCH_LIKELY_EN)
PC  output  32  current fetch address
PCplus4  output  32  PC+4, to ID for link value
SquashIF  output  1  kill instruction being latched into IF/ID this edge
SquashID  output  1  kill instruction being latched into ID/EX this edge
Pending  output  1  redirect held awaiting end of stall (debug/hazard visibility)

Behaviour:
- Reset (async, any time, including mid-redirect): PC=RESET_VEC, FSM=RUN, SquashIF=0, SquashID=0, Pending=0; all pending redirect state cleared.
- PCplus4 = PC+32'd4, modulo 2^32; 32'hFFFFFFFC wraps to 0. Targets: bits [1:0] forced to 0 before loading.
- FSM states:
  - RUN
  - PEND_BR: branch redirect captured; target stored in internal PendTgt
  - PEND_EXC: exception redirect captured
- Priority each cycle: ExcReq > (BrValid&BrTaken) > JmpValid > sequential.
- RUN, Stall=0:
  - ExcReq: PC<=EXC_VEC; SquashIF=1, SquashID=1 (combinational, same cycle).
  - Taken branch: PC<=BrTarget. The delay slot sits in ID and proceeds. SquashIF=1 kills the instruction fetched after the delay slot. Net effect: exactly one bubble.
  - JmpValid only: PC<=JmpTarget; no squash, because the IF instruction is the delay slot.
  - Taken branch and JmpValid together: branch wins; the jump is ignored (a jump in a delay slot is architecturally undefined).
  - Otherwise: PC<=PCplus4.
- RUN, Stall=1:
  - PC holds.
  - ExcReq: go to PEND_EXC.
  - Taken branch: capture BrTarget, go to PEND_BR.
  - JmpValid is ignored; ID re-presents the jump after the stall.
  - Squash outputs are 0.
- PEND_BR, Stall=1: hold, Pending=1. ExcReq moves to PEND_EXC (overrides).
- PEND_BR, Stall=0: PC<=PendTgt, SquashIF=1, go to RUN. New BrValid/JmpValid inputs this cycle are ignored. ExcReq takes priority (EXC path, go to RUN).
- PEND_EXC, Stall=1: hold. PEND_EXC, Stall=0: PC<=EXC_VEC, SquashIF=SquashID=1, go to RUN.
- Pending=1 exactly in the PEND_* states (registered).
- Latency: redirect visible on PC the cycle after the decision edge when unstalled. A branch not taken incurs zero penalty.

Optional Feature:
- Macro: BRANCH_LIKELY_EN.
- Defined: BrValid&~BrTaken&BrLikely nullifies the delay slot by asserting SquashID=1 that cycle; PC advances sequentially. Under Stall this case is captured in an extra state PEND_NULL, and the squash is issued on stall release.
- Undefined: BrLikely port is present but ignored; no PEND_NULL state exists.

Decomposition:
- Shared mips package/header holds:
  - RESET_VEC/EXC_VEC defaults
  - FSM state encodings (RUN, PEND_BR, PEND_EXC, PEND_NULL)
  - next-PC select codes (SEL_SEQ, SEL_BR, SEL_JMP, SEL_EXC, SEL_PEND)
- One natural sub-module: pc_nextsel, a pure combinational next-PC mux plus squash decode. The FSM and PC register stay in pc_unit.

Test Plan:
- Reset then 3 free-run cycles -> PC = BFC00000, BFC00004, BFC00008. Reset asserted mid-PEND_BR -> PC=BFC00000, Pending=0.
- PC=00400010, BrValid=1, BrTaken=1, BrTarget=00400100 -> SquashIF=1 that cycle; next PC=00400100; SquashID=0.
- JmpValid=1, JmpTarget=00401003 -> next PC=00401000, no squash. Same cycle with a taken branch to 00400200 -> PC=00400200.
- Taken branch with Stall=1 for 3 cycles -> PC frozen, Pending=1. On release: PC<=target, SquashIF=1, Pending=0.
- ExcReq with concurrent taken branch -> PC=BFC00180, SquashIF=SquashID=1. PC=FFFFFFFC sequential -> 00000000.
- BRANCH_LIKELY_EN: BrValid=1, BrTaken=0, BrLikely=1 -> SquashID=1, PC+4. Without the macro -> SquashID=0.
